// File: rtl/mu0_io_pkg.sv
// Shared definitions for the MU0 UART transmit port: register map, STATUS layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mu0_io_pkg;

    // Register offsets within the 2-word window.
    localparam logic REG_TXDATA = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // STATUS bit positions.
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_CNT_LO = 4;

    // STATUS word as seen on the bus; field order matches the bit positions above.
    typedef struct packed {
        logic [7:0] rsvd;
        logic [3:0] count;
        logic       ovf;
        logic       busy;
        logic       empty;
        logic       full;
    } status_t;

    // Transmit FSM states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/mu0_io_fifo.sv
// Byte FIFO with wrapping pointers and show-ahead read data.
// Latency: a pushed byte is visible on pop_dat the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module mu0_io_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic [7:0]               push_dat,
    input  logic                     pop,
    output logic [7:0]               pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mu0_uart_tx_port.sv
// MU0 memory-mapped 8N1 UART transmitter with a byte FIFO and sticky overflow flag.
// Latency: push at edge k into an idle, empty port drives the start bit after edge k+1; frame = 10*BAUD_DIV cycles.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged in STATUS.
module mu0_uart_tx_port
    import mu0_io_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'hFF0,
    parameter int          BAUD_DIV   = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [11:0] Addr,
    input  logic [15:0] Dout,
    input  logic        Wr,
    output logic [15:0] Rdata,
    output logic        Sel,
    output logic        TxD,
    output logic        Irq
);

    // Bus decode
    logic [11:0] addr_off;
    logic        reg_off;
    logic        sel;
    logic        tx_push;
    logic        stat_wr;
    logic        unused_dout_hi;

    // FIFO interface
    logic                        fifo_pop;
    logic [7:0]                  fifo_dat;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Transmitter state
    tx_state_t   state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        txd_q;
    logic        baud_end;
    logic        busy;
    logic        ovf;
    status_t     status;

    // Offset arithmetic handles any base, odd or even.
    assign addr_off       = Addr - BASE_ADDR;
    assign sel            = (addr_off[11:1] == 11'd0);
    assign reg_off        = addr_off[0];
    assign tx_push        = Wr && sel && (reg_off == REG_TXDATA);
    assign stat_wr        = Wr && sel && (reg_off == REG_STATUS);
    assign unused_dout_hi = ^Dout[15:8];

    assign baud_end = (baud_cnt == 16'(BAUD_DIV - 1));
    assign busy     = (state != ST_IDLE);
    // Pop on the same edge that loads the shift register: from IDLE, or at the end of STOP.
    assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

    mu0_io_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .push     (tx_push),
        .push_dat (Dout[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Sticky overflow: set on a dropped push, cleared by writing 1 to its STATUS bit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ovf <= 1'b0;
        end else if (tx_push && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
        end else if (stat_wr && Dout[STAT_OVF]) begin
            ovf <= 1'b0;
        end
    end

    // Transmit FSM with baud and bit counters; TxD is registered here.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!fifo_empty) begin
                        shreg <= fifo_dat;
                        txd_q <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd_q    <= shreg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            txd_q <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            txd_q   <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        // Chain straight into the next start bit so frames have no idle gap.
                        if (!fifo_empty) begin
                            shreg <= fifo_dat;
                            txd_q <= 1'b0;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

    // Assemble STATUS and the read mux; TXDATA and unselected addresses read as zero.
    always_comb begin
        status       = '0;
        status.count = 4'(fifo_count);
        status.ovf   = ovf;
        status.busy  = busy;
        status.empty = fifo_empty;
        status.full  = fifo_full;
        Rdata        = 16'h0000;
        if (sel && (reg_off == REG_STATUS)) begin
            Rdata = status;
        end
    end

    assign Sel = sel;
    assign TxD = txd_q;
    assign Irq = fifo_empty && !busy;

endmodule

// File: tb/tb_mu0_uart_tx_port.sv
module tb_mu0_uart_tx_port;

    logic        Clk;
    logic        Reset;
    logic [11:0] Addr;
    logic [15:0] Dout;
    logic        Wr;
    logic [15:0] Rdata;
    logic        Sel;
    logic        TxD;
    logic        Irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_frm;
    logic [9:0] frm;

    mu0_uart_tx_port #(
        .BASE_ADDR  (12'hFF0),
        .BAUD_DIV   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Addr  (Addr),
        .Dout  (Dout),
        .Wr    (Wr),
        .Rdata (Rdata),
        .Sel   (Sel),
        .TxD   (TxD),
        .Irq   (Irq)
    );

    initial Clk = 1'b0;
    always #50 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge; returns at the next negedge.
    task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
        Addr = a;
        Dout = d;
        Wr   = 1'b1;
        @(negedge Clk);
        Wr   = 1'b0;
        Addr = 12'h000;
        Dout = 16'h0000;
    endtask

    task automatic read_status(input string tag, input logic [15:0] exp);
        Addr = 12'hFF1;
        #1;
        chk(tag, Rdata, exp);
        Addr = 12'h000;
    endtask

    // Samples one frame starting with the next negedge, mid-bit.
    task automatic grab_frame(output logic [9:0] f);
        f = '0;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge Clk);
                if (c == 1) f[b] = TxD;
            end
        end
    endtask

    initial begin
        Reset = 1'b0;
        Addr  = 12'h000;
        Dout  = 16'h0000;
        Wr    = 1'b0;

        // Reset state
        @(negedge Clk);
        chk("rst_txd", {15'd0, TxD}, 16'd1);
        chk("rst_irq", {15'd0, Irq}, 16'd1);
        read_status("rst_status_in_reset", 16'h0002);
        @(negedge Clk);
        Reset = 1'b1;
        chk("rel_txd", {15'd0, TxD}, 16'd1);
        chk("rel_irq", {15'd0, Irq}, 16'd1);
        read_status("rel_status", 16'h0002);
        Addr = 12'hFF1; #1;
        chk("sel_status", {15'd0, Sel}, 16'd1);
        Addr = 12'hFF0; #1;
        chk("rd_txdata", Rdata, 16'h0000);
        chk("sel_txdata", {15'd0, Sel}, 16'd1);
        Addr = 12'hFF2; #1;
        chk("sel_ff2", {15'd0, Sel}, 16'd0);
        chk("rd_ff2", Rdata, 16'h0000);
        Addr = 12'hFEF; #1;
        chk("sel_fef", {15'd0, Sel}, 16'd0);

        // Single byte, pushed on the first edge after release
        bus_write(12'hFF0, 16'hAB55);
        chk("b55_txd_before_start", {15'd0, TxD}, 16'd1);
        chk("b55_irq_low", {15'd0, Irq}, 16'd0);
        exp_frm = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            chk($sformatf("b55_c%0d", i), {15'd0, TxD}, {15'd0, exp_frm[i/4]});
            if (i == 39) chk("b55_irq_busy", {15'd0, Irq}, 16'd0);
        end
        @(negedge Clk);
        chk("b55_irq_done", {15'd0, Irq}, 16'd1);
        chk("b55_txd_idle", {15'd0, TxD}, 16'd1);

        // Write to an address outside the window is ignored
        bus_write(12'hFF2, 16'h0055);
        read_status("ignored_write", 16'h0002);
        chk("ignored_txd", {15'd0, TxD}, 16'd1);

        // Overflow: 0x11 starts, then five pushes while it is in flight
        bus_write(12'hFF0, 16'h0011);
        for (int w = 0; w < 5; w++) begin
            logic [7:0] bv;
            bv = 8'hA1 + 8'(w * 17);
            bus_write(12'hFF0, {8'hEE, bv});
        end
        read_status("ovf_status", 16'h004D);
        bus_write(12'hFF1, 16'h0008);
        read_status("ovf_cleared", 16'h0045);

        // Full FIFO: push 0x3C on the edge where STOP of 0x11 pops the next byte
        repeat (34) @(negedge Clk);
        chk("ovf_stop_bit", {15'd0, TxD}, 16'd1);
        bus_write(12'hFF0, 16'h123C);
        chk("pp_next_start", {15'd0, TxD}, 16'd0);
        read_status("pp_status", 16'h0045);
        repeat (159) @(negedge Clk);
        chk("pp_b4_stop", {15'd0, TxD}, 16'd1);
        grab_frame(frm);
        chk("pp_last_frame", {6'd0, frm}, {6'd0, 1'b1, 8'h3C, 1'b0});
        @(negedge Clk);
        chk("pp_irq_done", {15'd0, Irq}, 16'd1);
        read_status("pp_status_done", 16'h0002);

        // Back-to-back frames 0x00 then 0xFF, 80 cycles with no gap
        bus_write(12'hFF0, 16'h0000);
        bus_write(12'hFF0, 16'h00FF);
        for (int i = 0; i < 80; i++) begin
            exp_frm = (i < 40) ? {1'b1, 8'h00, 1'b0} : {1'b1, 8'hFF, 1'b0};
            chk($sformatf("b2b_c%0d", i), {15'd0, TxD}, {15'd0, exp_frm[(i/4) % 10]});
            if (i == 79) chk("b2b_irq_busy", {15'd0, Irq}, 16'd0);
            @(negedge Clk);
        end
        chk("b2b_irq_done", {15'd0, Irq}, 16'd1);

        // Mid-frame reset during data bit 3 of 0xA5, with 0x77 still queued
        bus_write(12'hFF0, 16'h00A5);
        bus_write(12'hFF0, 16'h0077);
        repeat (17) @(negedge Clk);
        chk("mfr_bit3", {15'd0, TxD}, 16'd0);
        Reset = 1'b0;
        #1;
        chk("mfr_txd_now", {15'd0, TxD}, 16'd1);
        chk("mfr_irq_now", {15'd0, Irq}, 16'd1);
        read_status("mfr_status_in_reset", 16'h0002);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            chk($sformatf("mfr_quiet_c%0d", i), {15'd0, TxD}, 16'd1);
        end
        read_status("mfr_status_after", 16'h0002);
        chk("mfr_irq_after", {15'd0, Irq}, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mu0_uart_tx_port.md
MU0_UART_TX_PORT -- requirements
Module: mu0_uart_tx_port

Interface
REQ-001 Parameter BASE_ADDR, 12'hFF0, base of the 2-word register window on the MU0 bus.
REQ-002 Parameter BAUD_DIV, 16, Clk cycles per serial bit (legal range 2..65535).
REQ-003 Parameter FIFO_DEPTH, 4, transmit FIFO entries (power of two, 2..16).
REQ-004 Clk  input  1  system clock; all state changes on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Addr  input  12  MU0 address bus.
REQ-007 Dout  input  16  MU0 write data.
REQ-008 Wr  input  1  MU0 write strobe, active high.
REQ-009 Rdata  output  16  register read data, combinational from Addr and internal state.
REQ-010 Sel  output  1  high when Addr is BASE_ADDR or BASE_ADDR+1; the system read mux selects Rdata over memory when Sel is high.
REQ-011 TxD  output  1  serial line, idle high, 8N1, LSB first.
REQ-012 Irq  output  1  high while the FIFO is empty and the transmitter is idle.

Function
REQ-013 The block shall accept a write when Wr=1 and Sel=1 at a rising Clk edge; all other bus cycles shall be ignored.
REQ-014 A write to BASE+0 (TXDATA) shall push Dout[7:0] into the FIFO; Dout[15:8] shall be discarded.
REQ-015 A write to BASE+1 (STATUS) with Dout[3]=1 shall clear the sticky overflow flag; the other bits shall be ignored.
REQ-016 Read of BASE+0 shall return 16'h0000.
REQ-017 Read of BASE+1 shall return {8'h00, count[3:0], overflow, busy, empty, full} in bits [15:0], with full in bit 0.
REQ-018 When Sel=0, Rdata shall be 16'h0000.
REQ-019 A push while the FIFO is full shall drop the byte and set overflow, unless a pop occurs in the same cycle, in which case the push shall be accepted.
REQ-020 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-021 In IDLE with the FIFO non-empty, the FSM shall pop one byte into the shift register and enter START on the same edge.
REQ-022 START shall drive TxD=0, DATA shall drive 8 bits LSB first, STOP shall drive TxD=1; each bit shall last exactly BAUD_DIV cycles.
REQ-023 After STOP, the FSM shall go directly to START if the FIFO is non-empty, otherwise to IDLE, so frames are back-to-back with no idle gap.
REQ-024 Latency: for a push at edge k into an empty FIFO with the FSM idle, TxD shall fall after edge k+1; a frame shall occupy 10*BAUD_DIV cycles.
REQ-025 busy shall be 1 in START, DATA and STOP; count shall be the FIFO occupancy, 0..FIFO_DEPTH.
REQ-026 A write to TXDATA during a frame shall not disturb the frame in progress.

Reset
REQ-027 On Reset low, the block shall set: FSM=IDLE, FIFO empty (count=0), overflow=0, TxD=1, Irq=1, baud and bit counters=0; Rdata and Sel shall follow Addr.
REQ-028 Reset asserted mid-frame shall abort the frame immediately, with TxD=1; no partial frame shall resume after Reset is released.
REQ-029 The first push shall be accepted at the first rising edge after Reset is deasserted.

Structure
REQ-030 Package mu0_io_pkg shall hold the register offsets (TXDATA=0, STATUS=1), the STATUS bit positions and the FSM state enumeration.
REQ-031 The FIFO shall be a separate sub-module mu0_io_fifo (parameter DEPTH, 8-bit data, push/pop/full/empty/count, wrapping pointers); the FSM and baud counter shall be in mu0_uart_tx_port.

Verification
REQ-032 Bench parameters: BAUD_DIV=4, FIFO_DEPTH=4, 100 ns Clk; Reset low for two cycles.
REQ-033 Reset: after Reset release -> TxD=1, Irq=1, STATUS read = 16'h0002.
REQ-034 Single byte: write 16'hAB55 to 12'hFF0 -> TxD sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, falling 1 edge after the write, then Irq=1 after 40 cycles.
REQ-035 Overflow: write five bytes back-to-back while the FSM is busy on an earlier byte -> fifth byte dropped, STATUS bit3=1, count=4; writing 16'h0008 to 12'hFF1 -> bit3=0.
REQ-036 Back-to-back: push 8'h00 and 8'hFF -> the second start bit follows the first stop bit with no idle cycle; total 80 cycles.
REQ-037 Full push+pop: FIFO full as a STOP->START pop occurs, push 8'h3C in that cycle -> accepted, overflow stays 0, 8'h3C transmitted last.
REQ-038 Mid-frame reset: assert Reset during DATA bit 3 -> TxD=1 immediately; after release, count=0 and no further frame is sent.
